// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller: FSM state
// encoding and the default memory-wait watchdog limit.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    localparam int unsigned MEM_TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Control bundle between the core datapath and the pipeline stall
// controller. The master side raises requests and consumes the stage
// enables; the slave side is the controller itself.
interface pipeline_stall_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             enable;
    logic             hazard;
    logic             branch_taken;
    logic             dmem_req;
    logic             dmem_ready;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             ex_mem_write;
    logic             mem_wb_bubble;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output enable, hazard, branch_taken, dmem_req, dmem_ready,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble,
               ex_mem_write, mem_wb_bubble, mem_timeout,
               stall_cycles, flush_count
    );

    modport slave (
        input  enable, hazard, branch_taken, dmem_req, dmem_ready,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble,
               ex_mem_write, mem_wb_bubble, mem_timeout,
               stall_cycles, flush_count
    );
endinterface

// File: rtl/pipeline_stall_ctrl_counter.sv
// Generic up-counter with synchronous clear (priority) and increment.
// Wraps modulo 2^W. Used for the memory-wait counter and the
// performance counters.
module ctrl_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count register: clear wins over increment.
    // NOTE: every flop here gets an async reset value; these are plain
    // registers, not a memory array, so resetting them is cheap and keeps
    // the counters deterministic out of reset.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central pipeline-control responder for the 5-stage core.
// Turns hazard, taken-branch and data-memory handshake into per-stage
// write enables, flushes and bubbles; holds an IDLE/RUN/MEM_WAIT FSM
// with a sticky memory-wait watchdog.
// Optional feature: define STALL_PERF_CNT_EN to implement the
// stall_cycles / flush_count performance counters (otherwise tied to 0).
module pipeline_stall_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
    parameter int unsigned CNT_W       = 32
) (
    input logic                  clk,
    input logic                  arst_n,
    pipeline_stall_ctrl_if.slave ctrl
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_e              state;
    logic                mem_timeout_q;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                freeze;
    logic                wait_expired;
    logic                wait_clr;
    logic                wait_inc;
    logic                pc_write;
    logic                if_id_write;
    logic                if_id_flush;
    logic                id_ex_bubble;
    logic                ex_mem_write;
    logic                mem_wb_bubble;

    // Stage controls, combinational from state and this cycle's requests.
    // NOTE: every output gets a default first so no path leaves a value
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b1;
        ex_mem_write  = 1'b0;
        mem_wb_bubble = 1'b1;
        freeze        = 1'b0;
        if ((state == RUN && ctrl.dmem_req && !ctrl.dmem_ready) ||
            (state == MEM_WAIT && !ctrl.dmem_ready)) begin
            // Whole pipe holds; MEM/WB gets a bubble, ID/EX keeps its contents.
            freeze       = 1'b1;
            id_ex_bubble = 1'b0;
        end else if (state == RUN || state == MEM_WAIT) begin
            ex_mem_write  = 1'b1;
            mem_wb_bubble = 1'b0;
            if (ctrl.hazard) begin
                // Hold PC and IF/ID, bubble into EX; branch re-resolves next cycle.
                id_ex_bubble = 1'b1;
            end else if (ctrl.branch_taken) begin
                pc_write     = 1'b1;
                if_id_write  = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b0;
            end else begin
                pc_write     = 1'b1;
                if_id_write  = 1'b1;
                id_ex_bubble = 1'b0;
            end
        end
    end

    assign wait_clr     = (state == RUN) && freeze;
    assign wait_inc     = (state == MEM_WAIT);
    assign wait_expired = (state == MEM_WAIT) && !ctrl.dmem_ready &&
                          (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

    ctrl_counter #(.W(WAIT_W)) u_wait_cnt (
        .clk    (clk),
        .arst_n (arst_n),
        .clr    (wait_clr),
        .inc    (wait_inc),
        .count  (wait_cnt)
    );

    // FSM state and sticky watchdog flag; ready beats timeout in MEM_WAIT.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state         <= IDLE;
            mem_timeout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ctrl.enable && !mem_timeout_q) state <= RUN;
                end
                RUN: begin
                    if (freeze)            state <= MEM_WAIT;
                    else if (!ctrl.enable) state <= IDLE;
                end
                MEM_WAIT: begin
                    if (ctrl.dmem_ready) begin
                        state <= RUN;
                    end else if (wait_expired) begin
                        state         <= IDLE;
                        mem_timeout_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef STALL_PERF_CNT_EN
    logic stall_inc;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    assign stall_inc = (state == RUN || state == MEM_WAIT) && !pc_write;

    ctrl_counter #(.W(CNT_W)) u_stall_cnt (
        .clk    (clk),
        .arst_n (arst_n),
        .clr    (1'b0),
        .inc    (stall_inc),
        .count  (stall_cnt)
    );

    ctrl_counter #(.W(CNT_W)) u_flush_cnt (
        .clk    (clk),
        .arst_n (arst_n),
        .clr    (1'b0),
        .inc    (if_id_flush),
        .count  (flush_cnt)
    );

    assign ctrl.stall_cycles = stall_cnt;
    assign ctrl.flush_count  = flush_cnt;
`else
    assign ctrl.stall_cycles = '0;
    assign ctrl.flush_count  = '0;
`endif

    assign ctrl.pc_write      = pc_write;
    assign ctrl.if_id_write   = if_id_write;
    assign ctrl.if_id_flush   = if_id_flush;
    assign ctrl.id_ex_bubble  = id_ex_bubble;
    assign ctrl.ex_mem_write  = ex_mem_write;
    assign ctrl.mem_wb_bubble = mem_wb_bubble;
    assign ctrl.mem_timeout   = mem_timeout_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed self-checking bench for pipeline_stall_ctrl (MEM_TIMEOUT=4).
// Control vector order: {pc_write, if_id_write, if_id_flush,
//                        id_ex_bubble, ex_mem_write, mem_wb_bubble}.
module tb_pipeline_stall_ctrl;

`ifdef STALL_PERF_CNT_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    localparam logic [5:0] V_IDLE = 6'b000101;
    localparam logic [5:0] V_ADV  = 6'b110010;
    localparam logic [5:0] V_HAZ  = 6'b000110;
    localparam logic [5:0] V_BR   = 6'b111010;
    localparam logic [5:0] V_FRZ  = 6'b000001;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   exp_stall = 0;
    int   exp_flush = 0;
    logic [5:0] ctrl_vec;

    pipeline_stall_ctrl_if #(.CNT_W(32)) bus ();

    pipeline_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .ctrl   (bus.slave)
    );

    always #5 clk = ~clk;

    assign ctrl_vec = {bus.pc_write, bus.if_id_write, bus.if_id_flush,
                       bus.id_ex_bubble, bus.ex_mem_write, bus.mem_wb_bubble};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_cnts(input string tag);
        check({tag, "_stall"}, bus.stall_cycles, PERF_EN ? exp_stall : 0);
        check({tag, "_flush"}, bus.flush_count,  PERF_EN ? exp_flush : 0);
    endtask

    task automatic drive(input logic en, hz, br, rq, rd);
        bus.enable       = en;
        bus.hazard       = hz;
        bus.branch_taken = br;
        bus.dmem_req     = rq;
        bus.dmem_ready   = rd;
    endtask

    // One cycle: drive, check controls mid-cycle, then cross the edge.
    // 'active' marks cycles spent in RUN or MEM_WAIT.
    task automatic step(input string tag, input logic en, hz, br, rq, rd,
                        input logic [5:0] exp, input bit active);
        drive(en, hz, br, rq, rd);
        #2;
        check(tag, ctrl_vec, exp);
        if (active && !exp[5]) exp_stall++;
        if (exp[3]) exp_flush++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0);
        #2;
        check("rst_ctrl", ctrl_vec, V_IDLE);
        check("rst_timeout", bus.mem_timeout, 1'b0);
        check_cnts("rst");
        @(posedge clk);
        #1;
        arst_n = 1'b1;

        for (int i = 0; i < 5; i++) step("idle_en0", 0, 0, 0, 0, 0, V_IDLE, 0);
        step("idle_en1", 1, 0, 0, 0, 0, V_IDLE, 0);
        step("run_adv",  1, 0, 0, 0, 0, V_ADV,  1);

        step("hazard",    1, 1, 0, 0, 0, V_HAZ, 1);
        check_cnts("after_hazard");
        step("after_haz", 1, 0, 0, 0, 0, V_ADV, 1);

        step("branch", 1, 0, 1, 0, 0, V_BR, 1);
        check_cnts("after_branch");

        step("haz_br", 1, 1, 1, 0, 0, V_HAZ, 1);
        check_cnts("after_haz_br");
        step("adv_b", 1, 0, 0, 0, 0, V_ADV, 1);

        // Three-cycle memory wait, completes on the 4th.
        for (int i = 0; i < 3; i++) step("mem_frz", 1, 0, 0, 1, 0, V_FRZ, 1);
        step("mem_done",  1, 0, 0, 1, 1, V_ADV, 1);
        step("mem_after", 1, 0, 0, 0, 0, V_ADV, 1);
        check_cnts("after_mem");

        // Ready in MEM_WAIT still honours a hazard.
        step("mw_frz", 1, 0, 0, 1, 0, V_FRZ, 1);
        step("mw_haz", 1, 1, 0, 1, 1, V_HAZ, 1);
        step("mw_adv", 1, 0, 0, 0, 0, V_ADV, 1);

        // Ready on the timeout cycle wins.
        for (int i = 0; i < 4; i++) step("edge_frz", 1, 0, 0, 1, 0, V_FRZ, 1);
        step("edge_ready", 1, 0, 0, 1, 1, V_ADV, 1);
        check("edge_no_timeout", bus.mem_timeout, 1'b0);
        step("edge_run", 1, 0, 0, 0, 0, V_ADV, 1);
        check_cnts("after_edge");

        // enable drop: current cycle advances, then IDLE.
        step("drop_adv",  0, 0, 0, 0, 0, V_ADV,  1);
        step("drop_idle", 0, 0, 0, 0, 0, V_IDLE, 0);
        step("re_idle",   1, 0, 0, 0, 0, V_IDLE, 0);
        step("re_adv",    1, 0, 0, 0, 0, V_ADV,  1);

        // Watchdog: 5 freeze cycles, then sticky timeout and IDLE.
        for (int i = 0; i < 5; i++) step("to_frz", 1, 0, 0, 1, 0, V_FRZ, 1);
        check("to_flag", bus.mem_timeout, 1'b1);
        for (int i = 0; i < 3; i++) step("to_idle", 1, 0, 0, 0, 0, V_IDLE, 0);
        check("to_sticky", bus.mem_timeout, 1'b1);
        check_cnts("after_timeout");

        // Reset clears the watchdog.
        arst_n = 1'b0;
        #1;
        exp_stall = 0;
        exp_flush = 0;
        check("rst2_timeout", bus.mem_timeout, 1'b0);
        check("rst2_ctrl", ctrl_vec, V_IDLE);
        check_cnts("rst2");
        @(posedge clk);
        #1;
        arst_n = 1'b1;
        step("rst2_idle", 1, 0, 0, 0, 0, V_IDLE, 0);
        step("rst2_adv",  1, 0, 0, 0, 0, V_ADV,  1);

        // Reset asserted mid-MEM_WAIT returns to IDLE at once.
        step("mid_frz0", 1, 0, 0, 1, 0, V_FRZ, 1);
        step("mid_frz1", 1, 0, 0, 1, 0, V_FRZ, 1);
        drive(1, 0, 0, 1, 0);
        #2;
        arst_n = 1'b0;
        #1;
        exp_stall = 0;
        exp_flush = 0;
        check("mid_rst_ctrl", ctrl_vec, V_IDLE);
        check_cnts("mid_rst");
        @(posedge clk);
        #1;
        arst_n = 1'b1;

        // Fresh wait after reset: full budget available again.
        step("post_idle", 1, 0, 0, 0, 0, V_IDLE, 0);
        step("post_adv",  1, 0, 0, 0, 0, V_ADV,  1);
        for (int i = 0; i < 4; i++) step("post_frz", 1, 0, 0, 1, 0, V_FRZ, 1);
        step("post_done", 1, 0, 0, 1, 1, V_ADV, 1);
        check("post_no_timeout", bus.mem_timeout, 1'b0);
        check_cnts("post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Central pipeline-control responder for the 5-stage core.
- Consumes the stall request from the ID-stage hazard detector, the taken-branch flag from the ID-stage branch comparator, and the data-memory handshake.
- Drives the per-stage register write enables, flushes and bubble inserts.
- Holds a small FSM for start-up and multi-cycle data-memory waits, plus a wait-timeout watchdog.

## Interface
Parameters:
- MEM_TIMEOUT, default 64: maximum cycles spent in MEM_WAIT before the watchdog fires; legal range 2..65535.
- CNT_W, default 32: width of the performance counters.

Ports (reset is asynchronous, active-low; all logic on one clock):
- clk  in  1  core clock, rising edge.
- arst_n  in  1  asynchronous active-low reset.
- enable  in  1  core run request.
- hazard  in  1  load-use / branch-operand stall request from ID.
- branch_taken  in  1  branch/jump in ID resolved taken this cycle.
- dmem_req  in  1  MEM stage issues a load or store.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_write  out  1  PC register load enable.
- if_id_write  out  1  IF/ID write enable.
- if_id_flush  out  1  IF/ID cleared to NOP.
- id_ex_bubble  out  1  ID/EX loaded with NOP control.
- ex_mem_write  out  1  EX/MEM write enable.
- mem_wb_bubble  out  1  MEM/WB loaded with NOP control.
- mem_timeout  out  1  sticky watchdog flag.
- stall_cycles  out  CNT_W  count of cycles with pc_write=0 while in RUN or MEM_WAIT.
- flush_count  out  CNT_W  count of if_id_flush assertions.

## Operation
The FSM is registered; all control outputs are combinational from state and inputs.

States:
- IDLE
  - Outputs: all write enables 0, flush 0, id_ex_bubble 1, mem_wb_bubble 1.
  - enable=1 and mem_timeout=0 → RUN.
- RUN: evaluates the following in priority order.
  1. dmem_req=1 and dmem_ready=0 → freeze.
     - pc_write, if_id_write and ex_mem_write are 0; mem_wb_bubble is 1.
     - id_ex_bubble is 0 (ID/EX holds).
     - Next state MEM_WAIT.
  2. hazard=1 → pc_write=0, if_id_write=0, id_ex_bubble=1; all other stages advance.
  3. branch_taken=1 → pc_write=1 (loads the target), if_id_write=1, if_id_flush=1.
  4. Otherwise → all write enables 1, no flush, no bubble.
  - enable=0 in RUN with no freeze → IDLE next cycle; the current cycle still advances.
- MEM_WAIT
  - Freeze outputs as in RUN case 1 while dmem_ready=0.
  - dmem_ready=1 → outputs are the RUN evaluation with case 1 skipped; next state RUN.
  - Wait counter reaches MEM_TIMEOUT-1 with dmem_ready=0 → set mem_timeout; next state IDLE.
- mem_timeout:
  - Cleared only by reset.
  - While set, IDLE is not exited.

Wait counter:
- Cleared on entry to MEM_WAIT.
- Increments each MEM_WAIT cycle.
- Width is $clog2(MEM_TIMEOUT+1).

Simultaneous events:
- hazard and branch_taken together → hazard wins; the branch re-resolves next cycle.
- dmem_ready=1 and timeout on the same cycle → ready wins.

## Timing
- Reset values:
  - State is IDLE.
  - pc_write, if_id_write, if_id_flush and ex_mem_write are 0.
  - id_ex_bubble and mem_wb_bubble are 1.
  - mem_timeout is 0; counters are 0.
- Latency:
  - Control outputs respond in the same cycle as their inputs, with no registered delay.
  - State changes take effect on the next edge.
- A single hazard cycle costs exactly one bubble.
- An N-cycle memory wait costs N freeze cycles: the first in RUN, the remaining N-1 in MEM_WAIT.
- Reset asserted mid-MEM_WAIT → IDLE immediately; the wait counter clears.
- Counters wrap modulo 2^CNT_W.

## Configuration
- STALL_PERF_CNT_EN defined: stall_cycles and flush_count are implemented and update on each rising edge.
- STALL_PERF_CNT_EN undefined: both ports remain, are driven constant 0, and no counter flops are synthesised.

## Structure
- Package pipeline_ctrl_pkg holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, MEM_WAIT=2'd2);
  - the default MEM_TIMEOUT constant.
- One sub-module, ctrl_counter: a parameterised-width counter with clear and increment.
- ctrl_counter is instantiated for the wait counter and for each performance counter.

## Test plan
- Reset release, enable=0 for 5 cycles:
  - outputs hold reset values;
  - the cycle after enable=1, all write enables read 1.
- RUN, hazard=1 for one cycle → that cycle: pc_write=0, if_id_write=0, id_ex_bubble=1; stall_cycles=1 afterwards.
- branch_taken=1 with hazard=0 → if_id_flush=1, pc_write=1; flush_count=1.
- hazard=1 and branch_taken=1 together → no flush; id_ex_bubble=1.
- dmem_req=1 with dmem_ready low for 3 cycles, high on the 4th:
  - 3 freeze cycles;
  - the 4th cycle advances;
  - state returns to RUN.
- MEM_TIMEOUT=4, dmem_ready stuck 0 → mem_timeout=1 after 5 freeze cycles, state IDLE; enable=1 does not restart until reset.
